mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single unified memory port between two requesters: instruction fetch (read-only) and data access (load/store).
- Sits between the CPU core and the memory model. The memory is instantiated alongside the core in the cpu_tb-level system.
- Sequences each access with a registered FSM and tolerates variable memory latency.
- Provides bounded-priority arbitration so fetch is never starved, plus a per-access timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_DSTREAK, 4, consecutive data grants allowed while if_req is pending before fetch is forced.
- TIMEOUT, 64, BUSY cycles allowed without mem_ready before the access is aborted.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DW  fetched word, valid while if_ack=1
- if_err  out  1  pulses with if_ack on timeout
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=store, 0=load
- d_be  in  DW/8  store byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DW  load data, valid while d_ack=1
- d_err  out  1  pulses with d_ack on timeout
- mem_req  out  1  memory access active
- mem_we  out  1  memory write
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the current access this cycle

Behaviour:
- Reset: when rst=0 at a rising edge, state<=IDLE. All outputs <=0, streak and timeout counters <=0.
- Reset mid-access: mem_req drops at that edge, no ack or err is issued, and the in-flight access is discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE, arbitration at each edge:
  - No request: stay in IDLE.
  - Only one of if_req/d_req: grant it.
  - Both: grant data unless streak==MAX_DSTREAK, in which case grant fetch.
  - On grant: latch owner, addr, we, be and wdata into the mem_* registers, set mem_req=1, tcnt<=0, go to BUSY_I or BUSY_D.
  - A fetch grant always drives mem_we=0 and mem_be=0.
- Streak counter:
  - Increments on a data grant while if_req=1, saturating at MAX_DSTREAK.
  - Clears on any fetch grant, and on any data grant while if_req=0.
- BUSY_x:
  - mem_* outputs are held stable.
  - If mem_ready=1: capture mem_rdata into the owner's rdata register (0 if the access was a write), set owner ack=1, mem_req<=0, go to DONE.
  - Else if tcnt==TIMEOUT-1: owner ack=1, owner err=1, owner rdata=0, mem_req<=0, go to DONE.
  - Else tcnt<=tcnt+1.
- DONE:
  - Ack, err and rdata are visible for exactly this cycle.
  - Requests are ignored this cycle; they are cleared to 0 at the next edge and the FSM returns to IDLE.
  - The dead cycle gives the requester one edge to drop req or present a new address.
  - A req still high in IDLE after that is treated as a new access.
- Timing:
  - Minimum latency is req-sample edge to ack = 2 edges, when mem_ready is asserted in the first BUSY cycle.
  - Peak throughput is one access per 3 cycles.
- mem_ready while in IDLE or DONE is ignored.
- The non-owner's ack, err and rdata stay 0.

Test Plan:
- Reset: rst=0 for 2 edges with both reqs high → all outputs 0, no mem_req. Release rst → data is granted first (mem_addr=d_addr).
- Single fetch, memory ready immediately: if_req, if_addr=0x3000, mem_rdata=0x8C010004 → mem_req high 1 cycle, then if_ack=1 with if_rdata=0x8C010004, then IDLE.
- Store with 3-cycle memory latency: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF → mem_* stable for 3 cycles, d_ack after mem_ready, d_rdata=0.
- Starvation bound with MAX_DSTREAK=4: d_req and if_req held high continuously, each access reissued → grants D,D,D,D,I,D,D,D,D,I….
- Timeout with TIMEOUT=64: mem_ready held 0 → mem_req high exactly 64 cycles, then d_ack=1, d_err=1, d_rdata=0, then IDLE.
- Reset mid-BUSY: rst=0 in the 2nd BUSY cycle → mem_req 0 after that edge, no ack ever issued; a later mem_ready is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between instruction fetch and data access.
// Data wins ties until MAX_DSTREAK back-to-back data grants, then fetch is forced.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready
);

    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            if_ack_q, if_ack_d;
    logic            if_err_q, if_err_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic            d_ack_q, d_ack_d;
    logic            d_err_q, d_err_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            streak_full;
    logic            done_ok;
    logic            done_to;
    logic [DW-1:0]   done_rdata;

    assign streak_full = (streak_q == SW'(MAX_DSTREAK));

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tcnt_d      = tcnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = '0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = '0;
        done_ok     = 1'b0;
        done_to     = 1'b0;
        done_rdata  = '0;

        case (state_q)
            IDLE: begin
                if (d_req && !(if_req && streak_full)) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    tcnt_d      = '0;
                    if (!if_req)
                        streak_d = '0;
                    else if (!streak_full)
                        streak_d = streak_q + SW'(1);
                end else if (if_req) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    tcnt_d      = '0;
                    streak_d    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    done_ok    = 1'b1;
                    done_rdata = mem_we_q ? '0 : mem_rdata;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    done_to = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
                // Completion and abort share the handoff; only err differs.
                if (done_ok || done_to) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (state_q == BUSY_D) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = done_to;
                        d_rdata_d = done_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_err_d   = done_to;
                        if_rdata_d = done_rdata;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            tcnt_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tcnt_q      <= tcnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
